// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic {
    FS_LOAD = 1'b0,
    FS_RUN  = 1'b1
  } fs_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_STEP   = 4;

endpackage

// File: rtl/fetch_instr_mem.sv
// Word-addressed instruction store: synchronous write, combinational read.
module instr_mem #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Contents survive reset so a partial or previous program stays resident.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// IF stage: boot loader FSM, PC register, instruction memory and IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              R,
  input  logic              LE,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       if_instruction,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_valid,
  output logic              running
);

  localparam int CNT_W = ADDR_W - 2;

  fs_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ifi_q, ifi_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic              ifv_q, ifv_d;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  // Target is word aligned; the low byte-offset bits are dropped.
  logic [1:0] unused_tgt_lsb;
  assign unused_tgt_lsb = branch_target[1:0];

  instr_mem #(.AW(CNT_W), .DW(32)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cnt_q),
    .wdata (load_data),
    .raddr (pc_q[ADDR_W-1:2]),
    .rdata (mem_rdata)
  );

  // Next-state: loader writes in FS_LOAD; branch beats LE in FS_RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    ifi_d   = ifi_q;
    ifpc_d  = ifpc_q;
    ifv_d   = ifv_q;
    mem_we  = 1'b0;
    unique case (state_q)
      FS_LOAD: begin
        if (load_valid) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (load_last || (cnt_q == {CNT_W{1'b1}})) state_d = FS_RUN;
        end
      end
      FS_RUN: begin
        if (branch_taken) begin
          pc_d   = {branch_target[ADDR_W-1:2], 2'b00};
          ifi_d  = NOP_INSTR;
          ifpc_d = '0;
          ifv_d  = 1'b0;
        end else if (LE) begin
          ifi_d  = mem_rdata;
          ifpc_d = pc_q;
          ifv_d  = 1'b1;
          pc_d   = pc_q + ADDR_W'(PC_STEP);
        end
      end
      default: state_d = FS_LOAD;
    endcase
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= FS_LOAD;
      cnt_q   <= '0;
      pc_q    <= '0;
      ifi_q   <= NOP_INSTR;
      ifpc_q  <= '0;
      ifv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ifi_q   <= ifi_d;
      ifpc_q  <= ifpc_d;
      ifv_q   <= ifv_d;
    end
  end

  assign load_ready     = (state_q == FS_LOAD);
  assign running        = (state_q == FS_RUN);
  assign pc_out         = pc_q;
  assign if_instruction = ifi_q;
  assign if_pc          = ifpc_q;
  assign if_valid       = ifv_q;

endmodule
